// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin drain of four source FIFOs into one
// destination FIFO. At most one pop per cycle. Each popped word is forwarded
// to the destination exactly two cycles after its pop. The scheduler honours
// the destination almost-full (pause) flag and keeps a wrapping transfer
// counter for each source.

module fifo_rr_scheduler #(
   parameter int BUS_SIZE  = 5,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [3:0]           empty,
   input  logic [3:0]           src_valid,
   input  logic [BUS_SIZE-1:0]  src_data0,
   input  logic [BUS_SIZE-1:0]  src_data1,
   input  logic [BUS_SIZE-1:0]  src_data2,
   input  logic [BUS_SIZE-1:0]  src_data3,
   input  logic                 pause_dest,
   output logic [3:0]           pop,
   output logic                 push_dest,
   output logic [BUS_SIZE-1:0]  data_out,
   output logic [1:0]           src_id,
   output logic [1:0]           state,
   input  logic [1:0]           cnt_sel,
   output logic [CNT_WIDTH-1:0] cnt_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARB   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   state_t state_q, state_d;

   // Round-robin pointer: the source granted most recently.
   logic [1:0] last_q, last_d;

   // Pop issued in the previous cycle, so the word arrives this cycle.
   logic       pend_vld_q, pend_vld_d;
   logic [1:0] pend_id_q, pend_id_d;

   // Registered destination-side outputs.
   logic                out_vld_q, out_vld_d;
   logic [BUS_SIZE-1:0] out_data_q, out_data_d;
   logic [1:0]          out_id_q, out_id_d;

   logic [CNT_WIDTH-1:0] cnt_q [4];
   logic [CNT_WIDTH-1:0] cnt_d [4];

   logic                any_ne;
   logic                pop_en;
   logic                grant_vld;
   logic [1:0]          grant_id;
   logic [1:0]          idx;
   logic                cap;
   logic [BUS_SIZE-1:0] sel_data;

   assign any_ne = ~&empty;
   assign pop_en = (state_q == ARB) && enable && !pause_dest;

   // Search for the first non-empty source, starting just after last_q.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = last_q;
      idx       = last_q;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!grant_vld && !empty[idx]) begin
            grant_vld = 1'b1;
            grant_id  = idx;
         end
      end
      pop = (pop_en && grant_vld) ? (4'b0001 << grant_id) : 4'b0000;
   end

   // FSM next state. A pause that arrives while leaving IDLE sends the FSM to PAUSE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable && any_ne) state_d = pause_dest ? PAUSE : ARB;
         end
         ARB: begin
            if (pause_dest)                state_d = PAUSE;
            else if (!enable || !any_ne)   state_d = IDLE;
         end
         PAUSE: begin
            if (!pause_dest) state_d = (enable && any_ne) ? ARB : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Select the word returned by the source that was popped last cycle.
   always_comb begin
      case (pend_id_q)
         2'd0:    sel_data = src_data0;
         2'd1:    sel_data = src_data1;
         2'd2:    sel_data = src_data2;
         default: sel_data = src_data3;
      endcase
   end

   // Capture the returned word into the output stage and count the transfer.
   always_comb begin
      cap        = pend_vld_q && src_valid[pend_id_q];
      pend_vld_d = |pop;
      pend_id_d  = grant_id;
      last_d     = (|pop) ? grant_id : last_q;
      out_vld_d  = cap;
      out_data_d = cap ? sel_data  : out_data_q;
      out_id_d   = cap ? pend_id_q : out_id_q;
      for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
      if (cap) cnt_d[pend_id_q] = cnt_q[pend_id_q] + 1'b1;
   end

   // All state registers. Reset discards in-flight words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         last_q     <= 2'd3;
         pend_vld_q <= 1'b0;
         pend_id_q  <= 2'd0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_id_q   <= 2'd0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         pend_vld_q <= pend_vld_d;
         pend_id_q  <= pend_id_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_id_q   <= out_id_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign push_dest = out_vld_q;
   assign data_out  = out_data_q;
   assign src_id    = out_id_q;
   assign state     = state_q;
   assign cnt_out   = cnt_q[cnt_sel];

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Testbench for fifo_rr_scheduler. Source FIFOs are modelled as queues. A
// transaction-level reference model predicts grants, pushes, state and
// counters, and the bench compares the DUT against it every cycle.

module tb_fifo_rr_scheduler;

   localparam int BUS_SIZE  = 5;
   localparam int CNT_WIDTH = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 enable;
   logic [3:0]           empty;
   logic [3:0]           src_valid;
   logic [BUS_SIZE-1:0]  src_data [4];
   logic                 pause_dest;
   logic [3:0]           pop;
   logic                 push_dest;
   logic [BUS_SIZE-1:0]  data_out;
   logic [1:0]           src_id;
   logic [1:0]           state;
   logic [1:0]           cnt_sel;
   logic [CNT_WIDTH-1:0] cnt_out;

   fifo_rr_scheduler #(.BUS_SIZE(BUS_SIZE), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .reset(reset), .enable(enable), .empty(empty),
      .src_valid(src_valid),
      .src_data0(src_data[0]), .src_data1(src_data[1]),
      .src_data2(src_data[2]), .src_data3(src_data[3]),
      .pause_dest(pause_dest), .pop(pop), .push_dest(push_dest),
      .data_out(data_out), .src_id(src_id), .state(state),
      .cnt_sel(cnt_sel), .cnt_out(cnt_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]         due;
      logic [1:0]          id;
      logic [BUS_SIZE-1:0] data;
   } exp_t;

   logic [BUS_SIZE-1:0]  srcQ [4][$];
   exp_t                 expQ [$];
   logic [CNT_WIDTH-1:0] mCnt [4];
   int                   mState;
   int                   mLast;
   int                   cyc;
   int                   vectors;
   int                   miscompares;
   logic [3:0]           lastPop;
   bit                   randomFill;

   // Compare one observed value against the model's expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
      end
   endtask

   // Drive the scheduler control inputs for this cycle.
   task automatic applyStimulus(input logic en, input logic pz);
      enable     = en;
      pause_dest = pz;
      cnt_sel    = 2'($urandom_range(0, 3));
   endtask

   // Source side: return the word popped last cycle, add stray valids and optional refills.
   task automatic envDeliver();
      int j;
      src_valid = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (lastPop[i] && srcQ[i].size() > 0) begin
            src_data[i]  = srcQ[i].pop_front();
            src_valid[i] = 1'b1;
         end
      end
      if ($urandom_range(0, 7) == 0) begin
         j = $urandom_range(0, 3);
         if (!lastPop[j]) begin
            src_valid[j] = 1'b1;
            src_data[j]  = BUS_SIZE'($urandom);
         end
      end
      if (randomFill && $urandom_range(0, 2) == 0) begin
         j = $urandom_range(0, 3);
         srcQ[j].push_back(BUS_SIZE'($urandom));
      end
      for (int i = 0; i < 4; i++) empty[i] = (srcQ[i].size() == 0);
   endtask

   // Clear the reference model to its post-reset view.
   task automatic modelReset();
      mState = 0;
      mLast  = 3;
      expQ.delete();
      for (int i = 0; i < 4; i++) mCnt[i] = '0;
   endtask

   // Assert reset in the middle of a cycle and check that the outputs clear at once.
   task automatic doReset();
      @(negedge clk);
      cyc++;
      envDeliver();
      reset = 1'b1;
      #1;
      checkOutput("rst_pop", 32'(pop), 32'd0);
      checkOutput("rst_push", 32'(push_dest), 32'd0);
      checkOutput("rst_data", 32'(data_out), 32'd0);
      checkOutput("rst_srcid", 32'(src_id), 32'd0);
      checkOutput("rst_state", 32'(state), 32'd0);
      checkOutput("rst_cnt", 32'(cnt_out), 32'd0);
      modelReset();
      lastPop = 4'b0000;
   endtask

   // One clock cycle: apply inputs, compare the DUT with the model, then advance the model.
   task automatic stepCycle(input logic en, input logic pz);
      int   g;
      logic pushExp;
      logic anyNe;
      exp_t e;
      exp_t n;
      @(negedge clk);
      cyc++;
      reset = 1'b0;
      envDeliver();
      applyStimulus(en, pz);
      #1;
      pushExp = 1'b0;
      e       = '0;
      if (expQ.size() > 0 && expQ[0].due == 32'(cyc)) begin
         e       = expQ.pop_front();
         pushExp = 1'b1;
         mCnt[e.id] = mCnt[e.id] + 1'b1;
      end
      g = -1;
      if (mState == 1 && enable && !pause_dest) begin
         for (int k = 1; k <= 4; k++) begin
            if (g < 0 && srcQ[(mLast + k) % 4].size() > 0) g = (mLast + k) % 4;
         end
      end
      checkOutput("state", 32'(state), 32'(mState));
      checkOutput("pop", 32'(pop), (g >= 0) ? (32'd1 << g) : 32'd0);
      checkOutput("push_dest", 32'(push_dest), 32'(pushExp));
      if (pushExp) begin
         checkOutput("data_out", 32'(data_out), 32'(e.data));
         checkOutput("src_id", 32'(src_id), 32'(e.id));
      end
      checkOutput("cnt_out", 32'(cnt_out), 32'(mCnt[cnt_sel]));
      if (g >= 0) begin
         n.due  = 32'(cyc + 2);
         n.id   = 2'(g);
         n.data = srcQ[g][0];
         expQ.push_back(n);
         mLast = g;
      end
      lastPop = pop;
      anyNe = 1'b0;
      for (int i = 0; i < 4; i++) if (srcQ[i].size() > 0) anyNe = 1'b1;
      case (mState)
         0: if (enable && anyNe) mState = pause_dest ? 2 : 1;
         1: begin
            if (pause_dest)              mState = 2;
            else if (!enable || !anyNe)  mState = 0;
         end
         default: if (!pause_dest) mState = (enable && anyNe) ? 1 : 0;
      endcase
   endtask

   // Read one counter directly against a fixed expected count.
   task automatic checkCounter(input string tag, input logic [1:0] sel, input int expected);
      cnt_sel = sel;
      #1;
      checkOutput(tag, 32'(cnt_out), 32'(expected));
   endtask

   initial begin
      reset       = 1'b1;
      enable      = 1'b0;
      pause_dest  = 1'b0;
      cnt_sel     = 2'd0;
      src_valid   = 4'b0000;
      empty       = 4'hF;
      lastPop     = 4'b0000;
      randomFill  = 1'b0;
      cyc         = 0;
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 4; i++) src_data[i] = '0;
      modelReset();

      // Each source holds one word: the grants rotate 0,1,2,3.
      doReset();
      for (int i = 0; i < 4; i++) srcQ[i].push_back(BUS_SIZE'(i + 1));
      repeat (10) stepCycle(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) checkCounter("cnt_each_one", 2'(i), 1);

      // Only source 2 is non-empty: it is popped on five back-to-back cycles.
      doReset();
      for (int i = 0; i < 5; i++) srcQ[2].push_back(BUS_SIZE'(10 + i));
      repeat (10) stepCycle(1'b1, 1'b0);
      checkCounter("cnt_src2_five", 2'd2, 5);
      checkCounter("cnt_src0_zero", 2'd0, 0);

      // Sources 0 and 3 alternate.
      for (int i = 0; i < 3; i++) begin
         srcQ[0].push_back(BUS_SIZE'(20 + i));
         srcQ[3].push_back(BUS_SIZE'(24 + i));
      end
      repeat (10) stepCycle(1'b1, 1'b0);

      // Streaming, then pause, then resume.
      for (int i = 0; i < 4; i++) repeat (6) srcQ[i].push_back(BUS_SIZE'($urandom));
      repeat (5) stepCycle(1'b1, 1'b0);
      repeat (5) stepCycle(1'b1, 1'b1);
      repeat (20) stepCycle(1'b1, 1'b0);

      // Reset in the middle of a stream with words in flight.
      for (int i = 0; i < 4; i++) repeat (4) srcQ[i].push_back(BUS_SIZE'($urandom));
      repeat (4) stepCycle(1'b1, 1'b0);
      doReset();
      repeat (15) stepCycle(1'b1, 1'b0);

      // Counter wrap: 256 words from source 1 read back as 0, one more reads 1.
      doReset();
      repeat (256) srcQ[1].push_back(BUS_SIZE'($urandom));
      repeat (262) stepCycle(1'b1, 1'b0);
      checkCounter("cnt_wrap_zero", 2'd1, 0);
      srcQ[1].push_back(BUS_SIZE'(7));
      repeat (5) stepCycle(1'b1, 1'b0);
      checkCounter("cnt_wrap_one", 2'd1, 1);

      // Random traffic with random enable and pause.
      randomFill = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         stepCycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0));
      end
      randomFill = 1'b0;
      repeat (40) stepCycle(1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Round-robin scheduler draining four source FIFOs into one destination FIFO.
- Issues at most one pop per cycle to a non-empty source and forwards the popped word with push to the destination.
- Honours the destination's pause (almost-full) flag.
- Sits between the per-lane input FIFOs and the shared output FIFO; keeps per-source transfer counters for the bench.

Parameters:
- BUS_SIZE, 5, width of data words on every source and on the destination.
- CNT_WIDTH, 8, width of each per-source transfer counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  scheduling permitted when high.
- empty  input  4  empty flags of sources 3..0.
- src_valid  input  4  source i output word valid (registered FIFO output, one cycle after pop).
- src_data0..src_data3  input  BUS_SIZE each  source FIFO data outputs.
- pause_dest  input  1  destination almost-full flag.
- pop  output  4  one-hot pop strobes to sources (0000 when idle).
- push_dest  output  1  push strobe to destination.
- data_out  output  BUS_SIZE  word pushed to destination.
- src_id  output  2  source index of data_out, valid with push_dest.
- state  output  2  FSM state: IDLE=00, ARB=01, PAUSE=10.
- cnt_sel  input  2  selects counter for cnt_out.
- cnt_out  output  CNT_WIDTH  words delivered from source cnt_sel (combinational read).

Behaviour:
- Reset (async, any time):
  - pop=0, push_dest=0, data_out=0, src_id=0, state=IDLE.
  - All counters 0.
  - RR pointer last=3, so source 0 has first priority.
  - In-flight words are discarded; counters do not count them.
- FSM, evaluated on each edge:
  - IDLE -> ARB when enable=1, pause_dest=0 and any empty bit is 0.
  - ARB -> PAUSE when pause_dest=1.
  - ARB -> IDLE when enable=0 or all sources empty.
  - PAUSE -> ARB when pause_dest=0 and a source is non-empty and enable=1.
  - PAUSE -> IDLE when pause_dest=0 and (enable=0 or all empty).
- Grant (ARB only, combinational from registered state and current inputs):
  - pop[i]=1 for the first i in order last+1, last+2, ... (mod 4) with empty[i]=0.
  - last<=i on that edge. pop is 0000 in IDLE and PAUSE.
  - pop is gated the same cycle pause_dest rises: no pop issued while pause_dest=1.
- Source contract:
  - empty updates on the same edge that consumes pop, so back-to-back pops of one source are legal.
  - A single non-empty source is popped every cycle until empty.
- Forwarding pipeline:
  - Cycle N: pop[i].
  - Cycle N+1: src_valid[i]=1 with src_data_i; scheduler registers it with id i.
  - Cycle N+2: push_dest=1, data_out, src_id=i.
  - Pop-to-push latency is exactly 2 cycles. Sustained throughput is 1 word/cycle.
- Pause and enable drain:
  - At most 2 words are in flight after pause_dest rises; both are still pushed.
  - The destination almost-full threshold must leave >=2 free slots. This is a system requirement on the destination, not checked here.
  - Dropping enable stops new pops only; in-flight words complete.
- Unexpected src_valid: src_valid for a source not popped in the previous cycle is ignored.
- Counter:
  - cnt[src_id] increments on every push_dest.
  - Wraps 2^CNT_WIDTH-1 -> 0 with no saturation and no flag.
- Simultaneous events:
  - pause_dest rising while entering ARB from IDLE -> go to PAUSE; no pop.
  - Reset overrides everything.

Test Plan:
- Reset then enable=1, sources 0..3 each hold 1 word (values 1,2,3,4) -> pop sequence 0001,0010,0100,1000 on consecutive cycles; push_dest for 4 cycles starting 2 cycles after first pop; data_out 1,2,3,4; src_id 0,1,2,3; each cnt=1.
- Only source 2 non-empty with 5 words -> pop=0100 for 5 consecutive cycles, then IDLE; cnt_sel=2 reads 5; other counters 0.
- Sources 0 and 3 each with 3 words -> grants alternate 0,3,0,3,0,3; no source granted twice while the other is non-empty.
- Streaming from all sources, pause_dest raised at cycle T -> pop=0000 from T; exactly 2 further pushes; state=PAUSE. Lowering pause resumes from the next source after last.
- Reset asserted mid-stream with 2 words in flight -> outputs 0 immediately (async); those words never pushed. After release, first grant goes to the lowest non-empty source.
- Source 1 fed 256 words, CNT_WIDTH=8 -> cnt_out for sel=1 reads 0 (wrap); after one more word reads 1.
